// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel window generator and the kernel core that consumes its windows.
// Window byte k = 3*i + j, i = row offset (0 = oldest row), j = column offset (0 = leftmost).
package sobel_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int DEF_PIX_W = 8;
    localparam int WIN_W     = 9 * DEF_PIX_W;

    localparam int W_TL = 0;
    localparam int W_TM = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MM = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BM = 7;
    localparam int W_BR = 8;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle; master is the pixel source and window sink, slave is the generator.
interface sobel_window_gen_if #(
    parameter int PIX_W = sobel_pkg::DEF_PIX_W
);

    logic [PIX_W-1:0]   pix_in;
    logic               pix_valid;
    logic               pix_ready;
    logic [9*PIX_W-1:0] win_out;
    logic               win_valid;
    logic               win_ready;
    logic               win_last;
    logic               frame_done;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_out, win_valid, win_last, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_out, win_valid, win_last, frame_done
    );

endinterface

// File: rtl/sobel_line_buffer.sv
// One image row of pixel storage: combinational read, synchronous write at the same address,
// so a read and write in the same cycle returns the previous row's pixel.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int  DEPTH = DEF_IMG_W,
    parameter int  WIDTH = DEF_PIX_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    // Row storage write; contents need no reset since rows are refilled before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers feed a shifting 3x3 register array that
// doubles as the output register; one window per interior pixel, one-slot output hold.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic               clk,
    input  logic               reset,
    sobel_window_gen_if.slave  bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int WW = 9 * PIX_W;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WW-1:0]    win_q, win_d;
    logic             win_valid_q, win_valid_d;
    logic             win_last_q, win_last_d;
    logic             frame_done_q, frame_done_d;
    logic             pix_ready_s;
    logic             acc_s;
    logic             emit_s;
    logic             col_end_s;
    logic             row_end_s;
    logic [PIX_W-1:0] lb0_rd_s;
    logic [PIX_W-1:0] lb1_rd_s;

    assign pix_ready_s = ~reset & ~(win_valid_q & ~bus.win_ready);
    assign acc_s       = bus.pix_valid & pix_ready_s;
    assign col_end_s   = (col_q == COL_LAST);
    assign row_end_s   = (row_q == ROW_LAST);
    assign emit_s      = acc_s & (col_q >= COL_FIRST) & (row_q >= ROW_FIRST);

    // lb0 holds row r-1 and lb1 holds row r-2 at the current column.
    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk     (clk),
        .we      (acc_s),
        .addr    (col_q),
        .wr_data (bus.pix_in),
        .rd_data (lb0_rd_s)
    );

    sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk     (clk),
        .we      (acc_s),
        .addr    (col_q),
        .wr_data (lb0_rd_s),
        .rd_data (lb1_rd_s)
    );

    // Next-state: window shift, raster counters and output handshake.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = win_valid_q;
        win_last_d   = win_last_q;
        frame_done_d = 1'b0;

        if (acc_s) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    win_d[(3*i+j)*PIX_W +: PIX_W] = win_q[(3*i+j+1)*PIX_W +: PIX_W];
                end
            end
            win_d[W_TR*PIX_W +: PIX_W] = lb1_rd_s;
            win_d[W_MR*PIX_W +: PIX_W] = lb0_rd_s;
            win_d[W_BR*PIX_W +: PIX_W] = bus.pix_in;

            if (col_end_s) begin
                col_d = {CW{1'b0}};
                if (row_end_s) begin
                    row_d        = {RW{1'b0}};
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            win_d = win_q;
        end

        // A fresh window overrides a consumption in the same cycle, so there is no bubble.
        if (emit_s) begin
            win_valid_d = 1'b1;
            win_last_d  = col_end_s & row_end_s;
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end else begin
            win_valid_d = win_valid_q;
            win_last_d  = win_last_q;
        end
    end

    // State registers; reset also drops any window still awaiting acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= {CW{1'b0}};
            row_q        <= {RW{1'b0}};
            win_q        <= {WW{1'b0}};
            win_valid_q  <= 1'b0;
            win_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_last_q   <= win_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.pix_ready  = pix_ready_s;
    assign bus.win_out    = win_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_last   = win_last_q;
    assign bus.frame_done = frame_done_q;

endmodule
